// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds the arbiter state encoding and the owner encoding used when granting.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    // Which requester wins a grant decision taken in IDLE.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Grant state corresponding to an owner.
    function automatic arb_state_t owner_state(input logic owner);
        return (owner == OWNER_D) ? ARB_GNT_D : ARB_GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating starvation counter for the memory port arbiter.
// Ports: clk, rst (sync, active-high), clr, inc, cnt (current count),
// at_limit (count has reached MAX). clr has priority over inc.
module arb_starve_ctr #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between fetch (read-only)
// and data (read/write) requesters. Data side wins unless fetch has been
// passed over STARVE_MAX times in a row.
// Ports: clk, rst (sync, active-high); fetch i_req/i_addr -> i_ack/i_rdata;
// data d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata; memory side
// mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_lim;
    logic              pick_d;
    logic              owner;
    logic              cnt_clr;
    logic              cnt_inc;

    // Data wins unless fetch is waiting and has hit the starvation limit.
    assign pick_d = d_req && !(i_req && starve_lim);
    assign owner  = pick_d ? OWNER_D : OWNER_I;

    // Completion is only recognised in the matching grant state, so a
    // stray mem_ack while idle produces nothing.
    assign i_ack   = (state_q == ARB_GNT_I) && mem_ack;
    assign d_ack   = (state_q == ARB_GNT_D) && mem_ack;
    assign i_rdata = i_ack ? mem_rdata : '0;
    assign d_rdata = d_ack ? mem_rdata : '0;

    // Count data completions that overtook a waiting fetch.
    assign cnt_inc = d_ack && i_req;
    assign cnt_clr = i_ack || (d_ack && !i_req);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_d || i_req) begin
                    state_d     = owner_state(owner);
                    mem_req_d   = 1'b1;
                    mem_we_d    = (owner == OWNER_D) ? d_we : 1'b0;
                    mem_addr_d  = (owner == OWNER_D) ? d_addr : i_addr;
                    mem_wdata_d = (owner == OWNER_D) ? d_wdata : '0;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    arb_starve_ctr #(
        .MAX   (STARVE_MAX),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (starve_cnt),
        .at_limit (starve_lim)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a latency-programmable
// memory responder; vector table plus starvation, reset and idle-ack cases.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          mem_lat = 1;
    int          lat_cnt = 0;
    logic        spur = 1'b0;
    logic [31:0] rd_val = 32'h0;

    int tests = 0;
    int fails = 0;
    int n_iack = 0;
    int n_dack = 0;

    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Memory model: ack mem_lat cycles after mem_req rises.
    always_comb begin
        mem_ack = spur | (mem_req && (lat_cnt == mem_lat));
    end
    assign mem_rdata = rd_val;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle: sample at negedge and run the protocol monitor.
    task automatic tick();
        @(negedge clk);
        if (i_ack) n_iack++;
        if (d_ack) n_dack++;
        if (rst) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            chk("mon_both_ack", {31'b0, i_ack && d_ack}, 32'd0);
            if (!i_ack) chk("mon_i_rdata_zero", i_rdata, 32'd0);
            if (!d_ack) chk("mon_d_rdata_zero", d_rdata, 32'd0);
            if (prev_req && !prev_ack) begin
                chk("mon_hold_req", {31'b0, mem_req}, 32'd1);
                chk("mon_hold_addr", mem_addr, prev_addr);
                chk("mon_hold_we", {31'b0, mem_we}, {31'b0, prev_we});
                chk("mon_hold_wdata", mem_wdata, prev_wdata);
            end
            if (prev_req && prev_ack)
                chk("mon_idle_gap", {31'b0, mem_req}, 32'd0);
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    // Wait for either ack; cyc = cycles from the first sampled cycle.
    task automatic wait_ack(input string name, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            tick();
            if (i_ack || d_ack) return;
            cyc++;
        end
        tests++;
        fails++;
        $display("FAIL %s: got timeout want ack", name);
    endtask

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        we;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_d;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          cyc;
        int          ni;
        int          nd;
        int          dl;
        int          exp_cnt;
        logic [3:0]  order;
        vec_t        v;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0,
                    32'h2002_0005, 3, 1'b0, 32'h40};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h48, 32'h80, 32'hDEAD_BEEF,
                    32'h1111_1111, 2, 1'b1, 32'h80};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0,
                    32'h1234_5678, 1, 1'b1, 32'h100};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h204, 32'h0BAD_F00D,
                    32'h5555_AAAA, 2, 1'b1, 32'h204};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0,
                    32'hCAFE_BABE, 1, 1'b0, 32'hFFFF_FFFC};

        rst = 1'b1;
        i_req = 1'b0;
        i_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        drive();
        drive();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        drive();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            drive();
            mem_lat = v.lat;
            rd_val  = v.rdata;
            i_req   = v.ireq;
            i_addr  = v.iaddr;
            d_req   = v.dreq;
            d_we    = v.we;
            d_addr  = v.daddr;
            d_wdata = v.wdata;
            ni = n_iack;
            wait_ack("vec_ack", cyc);
            chk("vec_d_ack", {31'b0, d_ack}, {31'b0, v.exp_d});
            chk("vec_i_ack", {31'b0, i_ack}, {31'b0, !v.exp_d});
            chk("vec_latency", 32'(cyc), 32'(v.lat + 1));
            chk("vec_mem_addr", mem_addr, v.exp_addr);
            chk("vec_mem_we", {31'b0, mem_we}, {31'b0, v.exp_d && v.we});
            if (v.exp_d && v.we)
                chk("vec_mem_wdata", mem_wdata, v.wdata);
            if (v.exp_d && !v.we)
                chk("vec_d_rdata", d_rdata, v.rdata);
            if (!v.exp_d)
                chk("vec_i_rdata", i_rdata, v.rdata);
            if (!v.ireq)
                chk("vec_no_i_ack", 32'(n_iack - ni), 32'd0);
            drive();
            if (v.exp_d) d_req = 1'b0;
            else i_req = 1'b0;
            if (v.exp_d && v.ireq) begin
                tick();
                chk("drain_idle", {31'b0, mem_req}, 32'd0);
                wait_ack("drain_ack", cyc);
                chk("drain_i_ack", {31'b0, i_ack}, 32'd1);
                chk("drain_addr", mem_addr, v.iaddr);
                chk("drain_we", {31'b0, mem_we}, 32'd0);
                chk("drain_rdata", i_rdata, v.rdata);
                drive();
                i_req = 1'b0;
            end
            tick();
        end

        // Starvation: three back-to-back loads against a waiting fetch.
        drive();
        mem_lat = 1;
        rd_val  = 32'h0000_0077;
        i_req   = 1'b1;
        i_addr  = 32'h400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        dl      = 0;
        exp_cnt = 0;
        order   = '0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("starve_ack", cyc);
            order[k] = d_ack;
            if (i_ack) chk("starve_i_addr", mem_addr, 32'h400);
            drive();
            if (order[k]) begin
                exp_cnt = i_req ? ((exp_cnt < 2) ? exp_cnt + 1 : 2) : 0;
                dl++;
                if (dl < 3) d_addr = d_addr + 32'd4;
                else d_req = 1'b0;
            end else begin
                exp_cnt = 0;
                i_req = 1'b0;
            end
            chk("starve_cnt", 32'(dut.starve_cnt), 32'(exp_cnt));
        end
        chk("starve_order", {28'b0, order}, 32'b1011);
        tick();

        // Reset while a load is in flight.
        drive();
        mem_lat = 5;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h500;
        tick();
        tick();
        chk("rstmid_granted", {31'b0, mem_req}, 32'd1);
        nd = n_dack;
        drive();
        rst   = 1'b1;
        d_req = 1'b0;
        tick();
        drive();
        rst = 1'b0;
        tick();
        chk("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstmid_no_dack", 32'(n_dack - nd), 32'd0);
        chk("rstmid_starve", 32'(dut.starve_cnt), 32'd0);
        chk("rstmid_state", 32'(dut.state_q), 32'(ARB_IDLE));
        drive();
        mem_lat = 1;
        rd_val  = 32'h0042_0013;
        i_req   = 1'b1;
        i_addr  = 32'h44;
        wait_ack("rstmid_i", cyc);
        chk("rstmid_i_ack", {31'b0, i_ack}, 32'd1);
        chk("rstmid_i_addr", mem_addr, 32'h44);
        chk("rstmid_i_lat", 32'(cyc), 32'd2);
        chk("rstmid_i_rdata", i_rdata, 32'h0042_0013);
        drive();
        i_req = 1'b0;
        tick();

        // Stray mem_ack while idle.
        drive();
        spur = 1'b1;
        ni = n_iack;
        nd = n_dack;
        tick();
        chk("spur_i_ack", {31'b0, i_ack}, 32'd0);
        chk("spur_d_ack", {31'b0, d_ack}, 32'd0);
        drive();
        spur = 1'b0;
        tick();
        chk("spur_state", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
        chk("spur_acks", 32'(n_iack - ni + n_dack - nd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
